// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging single-beat-at-a-time bursts onto a synchronous SRAM port.
// One transaction in flight; reads take two cycles per beat.
module axi_sram_slave #(
    parameter int unsigned SRAM_AW = 20
) (
    input  logic               aclk,
    input  logic               areset,
    // read address
    input  logic [3:0]         arid,
    input  logic [31:0]        araddr,
    input  logic [3:0]         arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    input  logic [1:0]         arlock,
    input  logic [3:0]         arcache,
    input  logic [2:0]         arprot,
    input  logic               arvalid,
    output logic               arready,
    // read data
    output logic [3:0]         rid,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic               rvalid,
    input  logic               rready,
    // write address
    input  logic [3:0]         awid,
    input  logic [31:0]        awaddr,
    input  logic [3:0]         awlen,
    input  logic [2:0]         awsize,
    input  logic [1:0]         awburst,
    input  logic [1:0]         awlock,
    input  logic [3:0]         awcache,
    input  logic [2:0]         awprot,
    input  logic               awvalid,
    output logic               awready,
    // write data
    input  logic [3:0]         wid,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    // write response
    output logic [3:0]         bid,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    // SRAM
    output logic               sram_en,
    output logic [3:0]         sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    typedef enum logic [2:0] {StIdle, StRIssue, StRBeat, StWData, StWResp} state_e;

    state_e      state_q, state_d;
    logic        last_was_wr_q, last_was_wr_d;
    logic [3:0]  rid_q, rid_d, bid_q, bid_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d, beat_q, beat_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic        err_q, err_d;
    logic        wl_err_q, wl_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        first_q, first_d;

    logic        sel_rd;
    logic        beat_last;
    logic [31:0] addr_next;
    logic        unused_inputs;

    assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    assign sel_rd    = arvalid & (~awvalid | last_was_wr_q);
    assign beat_last = (beat_q == len_q);
    assign addr_next = (burst_q == 2'b01) ? addr_q + (32'd1 << size_q) : addr_q;

    always_comb begin
        state_d       = state_q;
        last_was_wr_d = last_was_wr_q;
        rid_d         = rid_q;
        bid_d         = bid_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        size_d        = size_q;
        burst_d       = burst_q;
        err_d         = err_q;
        wl_err_d      = wl_err_q;
        rdata_d       = rdata_q;
        first_d       = 1'b0;

        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        rvalid     = 1'b0;
        rresp      = 2'b00;
        rlast      = 1'b0;
        rdata      = rdata_q;
        rid        = rid_q;
        bvalid     = 1'b0;
        bresp      = 2'b00;
        bid        = bid_q;
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'h0;

        unique case (state_q)
            StIdle: begin
                arready = arvalid & sel_rd;
                awready = awvalid & ~sel_rd;
                if (arready) begin
                    rid_d         = arid;
                    addr_d        = araddr;
                    len_d         = arlen;
                    size_d        = arsize;
                    burst_d       = arburst;
                    beat_d        = 4'd0;
                    err_d         = (arsize > 3'd2) | arburst[1];
                    wl_err_d      = 1'b0;
                    last_was_wr_d = 1'b0;
                    state_d       = StRIssue;
                end else if (awready) begin
                    bid_d         = awid;
                    addr_d        = awaddr;
                    len_d         = awlen;
                    size_d        = awsize;
                    burst_d       = awburst;
                    beat_d        = 4'd0;
                    err_d         = (awsize > 3'd2) | awburst[1];
                    wl_err_d      = 1'b0;
                    last_was_wr_d = 1'b1;
                    state_d       = StWData;
                end
            end
            StRIssue: begin
                sram_en   = ~err_q;
                sram_addr = addr_q[SRAM_AW-1:0];
                first_d   = 1'b1;
                state_d   = StRBeat;
            end
            StRBeat: begin
                // SRAM data is only valid in the first beat cycle; hold it afterwards
                rdata   = first_q ? (err_q ? 32'h0 : sram_rdata) : rdata_q;
                rdata_d = rdata;
                rvalid  = 1'b1;
                rresp   = err_q ? 2'b10 : 2'b00;
                rlast   = beat_last;
                if (rready) begin
                    if (beat_last) begin
                        state_d = StIdle;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = addr_next;
                        state_d = StRIssue;
                    end
                end
            end
            StWData: begin
                wready = 1'b1;
                if (wvalid) begin
                    sram_en    = 1'b1;
                    sram_we    = err_q ? 4'b0000 : wstrb;
                    sram_addr  = addr_q[SRAM_AW-1:0];
                    sram_wdata = wdata;
                    addr_d     = addr_next;
                    if (wlast != beat_last) wl_err_d = 1'b1;
                    if (beat_last) begin
                        state_d = StWResp;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            StWResp: begin
                bvalid = 1'b1;
                bresp  = (err_q | wl_err_q) ? 2'b10 : 2'b00;
                if (bready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            last_was_wr_q <= 1'b1;
            rid_q         <= 4'd0;
            bid_q         <= 4'd0;
            addr_q        <= 32'h0;
            len_q         <= 4'd0;
            beat_q        <= 4'd0;
            size_q        <= 3'd0;
            burst_q       <= 2'd0;
            err_q         <= 1'b0;
            wl_err_q      <= 1'b0;
            rdata_q       <= 32'h0;
            first_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_was_wr_q <= last_was_wr_d;
            rid_q         <= rid_d;
            bid_q         <= bid_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            size_q        <= size_d;
            burst_q       <= burst_d;
            err_q         <= err_d;
            wl_err_q      <= wl_err_d;
            rdata_q       <= rdata_d;
            first_q       <= first_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural SRAM and channel monitors.
module tb_axi_sram_slave;

    logic        aclk, areset;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, arready, awvalid, awready, wlast, wvalid, wready;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        rlast, rvalid, rready, bvalid, bready;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    axi_sram_slave #(.SRAM_AW(20)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        int          cyc;
    } rbeat_t;
    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bresp_t;

    rbeat_t rq[$];
    acc_t   acc[$];
    bresp_t bq[$];
    int     cyc = 0;
    int     ar_cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    // Unwritten SRAM words read back as 0x5A000000 | byte address.
    logic [31:0] mem [0:255];
    bit          mem_v [0:255];
    logic [31:0] cur;
    logic [7:0]  idx;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (sram_en) begin
            idx = sram_addr[9:2];
            cur = mem_v[idx] ? mem[idx] : (32'h5A000000 | {22'h0, sram_addr[9:2], 2'b00});
            if (sram_we == 4'b0000) begin
                sram_rdata <= cur;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) cur[8*b +: 8] = sram_wdata[8*b +: 8];
                mem[idx]   <= cur;
                mem_v[idx] <= 1'b1;
            end
        end
    end

    always @(negedge aclk) begin
        if (arvalid && arready) ar_cyc = cyc;
        if (rvalid && rready) rq.push_back('{rid, rdata, rresp, rlast, cyc});
        if (sram_en) acc.push_back('{sram_we, {12'h0, sram_addr}, sram_wdata});
        if (bvalid && bready) bq.push_back('{bid, bresp});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ar_set(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    endtask

    task automatic aw_set(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    endtask

    task automatic hs_ar();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge aclk);
            got = arready;
        end
        check("ar_handshake", got, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic hs_aw();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge aclk);
            got = awready;
        end
        check("aw_handshake", got, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        bit got = 0;
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge aclk);
            got = wready;
        end
        check("w_handshake", got, 1);
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_r(input int n);
        for (int i = 0; i < 60 && rq.size() < n; i++) begin
            @(negedge aclk); #1;
        end
        check("r_beat_count", rq.size(), n);
    endtask

    task automatic wait_b(input int n);
        for (int i = 0; i < 40 && bq.size() < n; i++) begin
            @(negedge aclk); #1;
        end
        check("b_count", bq.size(), n);
    endtask

    int  na, nr, nb;
    bit  got;

    initial begin
        areset = 1'b1;
        {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid} = '0;
        {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
        {wid, wdata, wstrb, wlast, wvalid} = '0;
        rready = 1'b1;
        bready = 1'b1;

        // reset state
        @(negedge aclk);
        check("rst_ready", {arready, awready, wready}, 3'b000);
        check("rst_valid", {rvalid, bvalid}, 2'b00);
        check("rst_sram", {sram_en, sram_we}, 5'h0);
        check("rst_hold", {rid, bid, rdata}, 40'h0);

        // both channels valid in the first cycle after reset: read wins
        @(posedge aclk); #1;
        areset = 1'b0;
        ar_set(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
        aw_set(4'd9, 32'h20, 4'd1, 3'd2, 2'b01);
        @(negedge aclk);
        check("tie1_ar", arready, 1);
        check("tie1_aw", awready, 0);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        wait_r(4);
        for (int i = 0; i < 4; i++) begin
            check("rd_addr", acc[i].addr, 32'h100 + 4 * i);
            check("rd_we", acc[i].we, 4'h0);
            check("rd_data", rq[i].data, 32'h5A000100 + 4 * i);
            check("rd_last", rq[i].last, (i == 3));
            check("rd_resp_id", {rq[i].resp, rq[i].id}, {2'b00, 4'd5});
            check("rd_timing", rq[i].cyc - ar_cyc, 2 + 2 * i);
        end
        // the pending write is served at the next idle
        hs_aw();
        w_beat(32'h11223344, 4'b0011, 1'b0);
        w_beat(32'h55667788, 4'b1111, 1'b1);
        wait_b(1);
        check("wr_cnt", acc.size(), 6);
        check("wr0", {acc[4].we, acc[4].addr}, {4'b0011, 32'h20});
        check("wr1", {acc[5].we, acc[5].addr}, {4'b1111, 32'h24});
        check("wr0_mem", mem[8], 32'h5A003344);
        check("wr_b", {bq[0].resp, bq[0].id}, {2'b00, 4'd9});

        // next tie goes to read; stall rready during the beat
        @(posedge aclk); #1;
        rready = 1'b0;
        ar_set(4'd3, 32'h10, 4'd0, 3'd2, 2'b01);
        aw_set(4'd7, 32'h40, 4'd0, 3'd3, 2'b01);
        @(negedge aclk);
        check("tie2_ar", arready, 1);
        check("tie2_aw", awready, 0);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge aclk); #1;
            got = rvalid;
        end
        check("stall_rvalid_seen", got, 1);
        na = acc.size();
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {rvalid, rlast, rid, rdata}, {1'b1, 1'b1, 4'd3, 32'h5A000010});
            @(negedge aclk); #1;
        end
        check("stall_no_sram", acc.size(), na);
        @(posedge aclk); #1;
        rready = 1'b1;
        wait_r(5);
        check("stall_beat", {rq[4].data, rq[4].last}, {32'h5A000010, 1'b1});

        // awsize=3: no byte enables, error response
        hs_aw();
        w_beat(32'hDEADBEEF, 4'b1111, 1'b1);
        wait_b(2);
        check("sz3_we", acc[acc.size() - 1].we, 4'h0);
        check("sz3_mem", mem_v[16], 1'b0);
        check("sz3_b", {bq[1].resp, bq[1].id}, {2'b10, 4'd7});

        // WRAP read: two zero beats, SLVERR, no SRAM access
        @(posedge aclk); #1;
        na = acc.size();
        ar_set(4'd2, 32'h30, 4'd1, 3'd2, 2'b10);
        hs_ar();
        wait_r(7);
        check("wrap_b0", {rq[5].data, rq[5].resp, rq[5].last}, {32'h0, 2'b10, 1'b0});
        check("wrap_b1", {rq[6].data, rq[6].resp, rq[6].last}, {32'h0, 2'b10, 1'b1});
        check("wrap_no_sram", acc.size(), na);

        // early wlast on a 3-beat write: all beats written, SLVERR
        na = acc.size();
        aw_set(4'd4, 32'h50, 4'd2, 3'd2, 2'b01);
        hs_aw();
        w_beat(32'h1, 4'hF, 1'b0);
        w_beat(32'h2, 4'hF, 1'b1);
        w_beat(32'h3, 4'hF, 1'b0);
        wait_b(3);
        check("wl_cnt", acc.size(), na + 3);
        for (int i = 0; i < 3; i++)
            check("wl_acc", {acc[na + i].we, acc[na + i].addr}, {4'hF, 32'h50 + 4 * i});
        check("wl_b", {bq[2].resp, bq[2].id}, {2'b10, 4'd4});

        // reset in the middle of a write burst
        aw_set(4'd1, 32'h60, 4'd3, 3'd2, 2'b01);
        hs_aw();
        w_beat(32'hA, 4'hF, 1'b0);
        wvalid = 1'b1; wdata = 32'hB; wstrb = 4'hF;
        areset = 1'b1;
        #1;
        check("rst_mid_wready", {wready, sram_en}, 2'b00);
        na = acc.size();
        nb = bq.size();
        @(posedge aclk); #1;
        areset = 1'b0;
        wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk); #1;
            check("rst_mid_idle", {wready, bvalid}, 2'b00);
        end
        check("rst_mid_no_sram", acc.size(), na);
        check("rst_mid_no_b", bq.size(), nb);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter SRAM_AW, default 20: number of byte-address bits driven to the SRAM; higher AXI address bits are ignored.
REQ-002 aclk  in  1  sole clock; every register samples on its rising edge.
REQ-003 areset  in  1  reset, asynchronous, active-high.
REQ-004 arid/araddr/arlen/arsize/arburst/arvalid  in  4/32/4/3/2/1  AXI3 read address channel from the mycpu_top master; arlock/arcache/arprot in and ignored.
REQ-005 arready  out  1  read address accept.
REQ-006 rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel; rready  in  1.
REQ-007 awid/awaddr/awlen/awsize/awburst/awvalid  in  4/32/4/3/2/1  write address channel; awlock/awcache/awprot in and ignored; awready  out  1.
REQ-008 wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data channel (wid ignored); wready  out  1.
REQ-009 bid/bresp/bvalid  out  4/2/1  write response; bready  in  1.
REQ-010 sram_en  out  1; sram_we  out  4 (byte enables); sram_addr  out  SRAM_AW; sram_wdata  out  32; sram_rdata  in  32, valid exactly one cycle after an sram_en with sram_we=0.

Function
REQ-011 SHALL use a single FSM with states IDLE, R_ISSUE, R_BEAT, W_DATA, W_RESP; only one transaction is in flight at a time.
REQ-012 In IDLE: arready = arvalid & sel_rd; awready = awvalid & ~sel_rd. sel_rd = arvalid & (~awvalid | last_was_wr). last_was_wr SHALL be a register updated on every accepted transaction.
REQ-013 AR handshake SHALL latch id, addr, len, size, burst, clear beat counter, set err = (arsize>2) | (arburst ∉ {FIXED 00, INCR 01}), and go to R_ISSUE.
REQ-014 R_ISSUE: sram_en=1, sram_we=0, sram_addr=addr[SRAM_AW-1:0]; next state R_BEAT.
REQ-015 R_BEAT: rvalid=1, rdata = sram_rdata captured in a register on entry (held stable while stalled), rresp = err ? 2'b10 : 2'b00, rlast = (beat==len), rid = latched id.
REQ-016 On rvalid&rready: if rlast, go to IDLE; else beat+1, addr += (1<<size) for INCR (32-bit wrap, no 4KB check), unchanged for FIXED, and go to R_ISSUE. Read throughput is therefore one beat per 2 cycles, and the first rvalid appears 2 cycles after the AR handshake.
REQ-017 In error bursts, SHALL still return len+1 beats with rdata=0, and sram_en SHALL stay 0.
REQ-018 AW handshake SHALL latch id/addr/len/size/burst, set err by the REQ-013 rule, and go to W_DATA.
REQ-019 W_DATA: wready=1; on wvalid: sram_en=1, sram_we = err ? 0 : wstrb, sram_addr=addr, sram_wdata=wdata, all in the same cycle (combinational from wvalid); address advances per REQ-016.
REQ-020 Beat count SHALL end the burst: the beat with beat==len moves to W_RESP. If wlast ≠ (beat==len) on any beat, err SHALL be set for the response only; writes already performed are not undone.
REQ-021 W_RESP: bvalid=1, bid = latched id, bresp = err ? 2'b10 : 2'b00; on bready go to IDLE.
REQ-022 Outputs not named active in the current state SHALL be 0; rdata/rid/bid hold their last values.

Reset
REQ-023 areset SHALL force IDLE asynchronously, with all valid/ready/sram_en/sram_we outputs = 0, last_was_wr=1 (read wins the first tie), beat=0, err=0, and rdata/rid/bid/latched fields = 0.
REQ-024 Reset mid-burst SHALL abandon the transaction with no further SRAM access and no response; the master is assumed reset concurrently.

Verification
REQ-025 Read arlen=3, arsize=2, INCR, araddr=0x100, rready=1 -> sram_addr 0x100,0x104,0x108,0x10C; 4 beats each 2 cycles apart; rlast on the 4th only; rresp=00.
REQ-026 Write awlen=1, INCR, addr 0x20, wstrb 4'b0011 then 4'b1111 -> sram_we 0011@0x20, 1111@0x24; bvalid after the 2nd beat with bresp=00 and bid=awid.
REQ-027 arvalid and awvalid both asserted in the first cycle after reset -> read served first; at the next IDLE write served; the next tie goes to read.
REQ-028 rready held low 5 cycles during R_BEAT -> rvalid/rdata/rlast stable, no extra sram_en.
REQ-029 arburst=WRAP, arlen=1 -> 2 beats, rdata=0, rresp=10, sram_en never asserted; awsize=3 write -> sram_we=0, bresp=10.
REQ-030 Write awlen=2 with wlast on the 2nd beat -> 3 SRAM writes, bresp=10; areset asserted in W_DATA -> immediately IDLE, wready=0, no bvalid.
